// File: rtl/bsram_arbiter.sv
// Round-robin arbiter sharing one BSRAM (separate read/write ports) between two clients.
// Optional power-up zero-fill sweep enabled by defining BSRAM_ARB_INIT_EN.
module bsram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c0_read,
    input  logic                  c0_write,
    input  logic [ADDR_WIDTH-1:0] c0_address,
    input  logic [DATA_WIDTH-1:0] c0_writeData,
    output logic                  c0_grant,
    output logic                  c0_readValid,
    output logic [DATA_WIDTH-1:0] c0_readData,
    input  logic                  c1_read,
    input  logic                  c1_write,
    input  logic [ADDR_WIDTH-1:0] c1_address,
    input  logic [DATA_WIDTH-1:0] c1_writeData,
    output logic                  c1_grant,
    output logic                  c1_readValid,
    output logic [DATA_WIDTH-1:0] c1_readData,
    output logic                  mem_readEnable,
    output logic [ADDR_WIDTH-1:0] mem_readAddress,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    output logic                  initDone
);

    logic c0Req;
    logic c1Req;
    logic arbActive;
    logic lastGrant;   // 1: client 1 was granted last, so client 0 wins the next contention

    assign c0Req = c0_read | c0_write;
    assign c1Req = c1_read | c1_write;

`ifdef BSRAM_ARB_INIT_EN
    localparam logic STATE_INIT = 1'b0;
    localparam logic STATE_ARB  = 1'b1;
    localparam logic [ADDR_WIDTH:0] INIT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic                state;
    logic [ADDR_WIDTH:0] initCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= STATE_INIT;
            initCount <= '0;
        end else if (state == STATE_INIT) begin
            initCount <= initCount + 1'b1;
            if (initCount == INIT_LAST) begin
                state <= STATE_ARB;
            end
        end
    end

    assign arbActive = !reset && (state == STATE_ARB);
    assign initDone  = (state == STATE_ARB);
`else
    assign arbActive = !reset;
    assign initDone  = 1'b1;
`endif

    always_comb begin
        c0_grant = 1'b0;
        c1_grant = 1'b0;
        if (arbActive) begin
            if (c0Req && c1Req) begin
                c0_grant = lastGrant;
                c1_grant = !lastGrant;
            end else begin
                c0_grant = c0Req;
                c1_grant = c1Req;
            end
        end
    end

    always_comb begin
        mem_readEnable   = 1'b0;
        mem_readAddress  = '0;
        mem_writeEnable  = 1'b0;
        mem_writeAddress = '0;
        mem_writeData    = '0;
        if (c0_grant) begin
            mem_readEnable   = c0_read;
            mem_writeEnable  = c0_write;
            mem_readAddress  = c0_address;
            mem_writeAddress = c0_address;
            mem_writeData    = c0_writeData;
        end else if (c1_grant) begin
            mem_readEnable   = c1_read;
            mem_writeEnable  = c1_write;
            mem_readAddress  = c1_address;
            mem_writeAddress = c1_address;
            mem_writeData    = c1_writeData;
        end
`ifdef BSRAM_ARB_INIT_EN
        if (!reset && state == STATE_INIT) begin
            mem_writeEnable  = 1'b1;
            mem_writeAddress = initCount[ADDR_WIDTH-1:0];
            mem_writeData    = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant    <= 1'b1;
            c0_readValid <= 1'b0;
            c1_readValid <= 1'b0;
            c0_readData  <= '0;
            c1_readData  <= '0;
        end else begin
            if (c0_grant) begin
                lastGrant <= 1'b0;
            end else if (c1_grant) begin
                lastGrant <= 1'b1;
            end
            c0_readValid <= c0_grant && c0_read;
            c1_readValid <= c1_grant && c1_read;
            if (c0_grant && c0_read) begin
                c0_readData <= mem_readData;
            end
            if (c1_grant && c1_read) begin
                c1_readData <= mem_readData;
            end
        end
    end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Directed bench for bsram_arbiter with a behavioural BSRAM model (combinational read, write forwarding).
// Covers the zero-fill sweep too when BSRAM_ARB_INIT_EN is defined.
module tb_bsram_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
`ifdef BSRAM_ARB_INIT_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          c0_read, c0_write, c1_read, c1_write;
    logic [AW-1:0] c0_address, c1_address;
    logic [DW-1:0] c0_writeData, c1_writeData;
    logic          c0_grant, c1_grant, c0_readValid, c1_readValid;
    logic [DW-1:0] c0_readData, c1_readData;
    logic          mem_readEnable, mem_writeEnable;
    logic [AW-1:0] mem_readAddress, mem_writeAddress;
    logic [DW-1:0] mem_readData, mem_writeData;
    logic          initDone;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] memArray [1<<AW];

    always #5 clock = ~clock;

    bsram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .c0_read(c0_read), .c0_write(c0_write), .c0_address(c0_address),
        .c0_writeData(c0_writeData), .c0_grant(c0_grant),
        .c0_readValid(c0_readValid), .c0_readData(c0_readData),
        .c1_read(c1_read), .c1_write(c1_write), .c1_address(c1_address),
        .c1_writeData(c1_writeData), .c1_grant(c1_grant),
        .c1_readValid(c1_readValid), .c1_readData(c1_readData),
        .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
        .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
        .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData),
        .initDone(initDone)
    );

    // BSRAM model: same-cycle read, write-to-read forwarding on matching address
    always_ff @(posedge clock) begin
        if (mem_writeEnable) memArray[mem_writeAddress] <= mem_writeData;
    end
    always_comb begin
        mem_readData = memArray[mem_readAddress];
        if (mem_writeEnable && mem_writeAddress == mem_readAddress) mem_readData = mem_writeData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
        c0_address = '0; c1_address = '0; c0_writeData = '0; c1_writeData = '0;
    endtask

    // Release reset and, in the sweep build, let the zero-fill finish
    task automatic release_reset();
        reset = 0;
        if (INIT_EN) begin
            for (int i = 0; i < (1 << AW); i++) tick();
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) memArray[i] = '0;
        idle();
        reset = 1;
        c0_read = 1; c0_address = 4'h3;
        tick(); tick();
        chk("reset_c0_grant", c0_grant, 0);
        chk("reset_c1_grant", c1_grant, 0);
        chk("reset_mem_re", mem_readEnable, 0);
        chk("reset_mem_we", mem_writeEnable, 0);
        chk("reset_mem_waddr", mem_writeAddress, 0);
        chk("reset_valid0", c0_readValid, 0);
        chk("reset_data0", c0_readData, 0);
        chk("reset_initDone", initDone, !INIT_EN);

        // c0_read held at 0x3 straight out of reset
        reset = 0;
        #1;
        if (INIT_EN) begin
            for (int i = 0; i < (1 << AW); i++) begin
                chk("init_grant0", c0_grant, 0);
                chk("init_done_low", initDone, 0);
                chk("init_we", mem_writeEnable, 1);
                chk("init_waddr", mem_writeAddress, i);
                chk("init_wdata", mem_writeData, 0);
                tick();
            end
            chk("init_done_high", initDone, 1);
        end
        chk("first_grant0", c0_grant, 1);
        chk("first_raddr", mem_readAddress, 4'h3);
        tick();
        c0_read = 0;
        chk("first_valid0", c0_readValid, 1);
        if (INIT_EN) chk("init_zero_data", c0_readData, 0);
        tick();
        chk("first_valid0_drop", c0_readValid, 0);

        // single client write then read
        c1_write = 1; c1_address = 4'h5; c1_writeData = 32'hDEADBEEF;
        #1;
        chk("c1w_grant1", c1_grant, 1);
        chk("c1w_grant0", c0_grant, 0);
        chk("c1w_we", mem_writeEnable, 1);
        chk("c1w_re", mem_readEnable, 0);
        chk("c1w_waddr", mem_writeAddress, 4'h5);
        chk("c1w_wdata", mem_writeData, 32'hDEADBEEF);
        tick();
        c1_write = 0; c1_read = 1;
        #1;
        chk("c1w_novalid", c1_readValid, 0);
        chk("c1r_grant1", c1_grant, 1);
        tick();
        c1_read = 0;
        chk("c1r_valid", c1_readValid, 1);
        chk("c1r_data", c1_readData, 32'hDEADBEEF);
        tick();
        chk("c1r_valid_drop", c1_readValid, 0);
        chk("c1r_data_hold", c1_readData, 32'hDEADBEEF);
        chk("idle_re", mem_readEnable, 0);

        // contention right after reset: c0 first, then alternate
        reset = 1;
        tick();
        release_reset();
        c0_read = 1; c0_address = 4'h1; c1_read = 1; c1_address = 4'h2;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("cont_grant0", c0_grant, (i % 2) == 0);
            chk("cont_grant1", c1_grant, (i % 2) == 1);
            chk("cont_raddr", mem_readAddress, ((i % 2) == 0) ? 4'h1 : 4'h2);
            tick();
            chk("cont_valid0", c0_readValid, (i % 2) == 0);
            chk("cont_valid1", c1_readValid, (i % 2) == 1);
        end
        idle();
        tick();
        chk("cont_end_valid0", c0_readValid, 0);
        chk("cont_end_valid1", c1_readValid, 0);

        // same-client read+write forwarding
        c0_read = 1; c0_write = 1; c0_address = 4'h7; c0_writeData = 32'h12345678;
        #1;
        chk("fwd_grant0", c0_grant, 1);
        chk("fwd_re", mem_readEnable, 1);
        chk("fwd_we", mem_writeEnable, 1);
        tick();
        c0_write = 0; c0_writeData = '0;
        chk("fwd_valid", c0_readValid, 1);
        chk("fwd_data", c0_readData, 32'h12345678);
        tick();
        c0_read = 0;
        chk("fwd_reread_data", c0_readData, 32'h12345678);

        // set lastGrant=1 via a lone c1 read, then cross-client write/read
        c1_read = 1; c1_address = 4'hB;
        tick();
        c1_read = 0;
        c0_write = 1; c0_address = 4'hA; c0_writeData = 32'hCAFEF00D;
        c1_read = 1; c1_address = 4'hA;
        #1;
        chk("xc_grant0", c0_grant, 1);
        chk("xc_grant1_wait", c1_grant, 0);
        tick();
        c0_write = 0;
        #1;
        chk("xc_grant1", c1_grant, 1);
        tick();
        c1_read = 0;
        chk("xc_valid1", c1_readValid, 1);
        chk("xc_data1", c1_readData, 32'hCAFEF00D);

        // reset mid-operation: c0 read granted (lastGrant=0), reset in the next cycle
        c0_read = 1; c0_address = 4'h7;
        #1;
        chk("mid_grant0", c0_grant, 1);
        tick();
        reset = 1;
        #1;
        chk("mid_reset_grant0", c0_grant, 0);
        tick();
        chk("mid_squash_valid", c0_readValid, 0);
        chk("mid_initDone", initDone, !INIT_EN);
        chk("mid_data_cleared", c0_readData, 0);
        c1_read = 1; c1_address = 4'h2;
        release_reset();
        chk("mid_lastgrant_c0", c0_grant, 1);
        chk("mid_lastgrant_c1", c1_grant, 0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
